// File: rtl/ntt_pkg.sv
// Shared types and helpers for the segment-pipelined modular add/sub datapath.
package ntt_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Control part of a pipeline stage record; the wide operand/result fields
  // change width from stage to stage and live beside it in the top.
  typedef struct packed {
    logic  valid;
    mode_e sub;
    logic  raw_c;
    logic  alt_c;
  } stage_ctl_t;

  function automatic int calc_nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/pg_seg_adder.sv
// SEG_W-bit combinational adder built from per-bit propagate/generate,
// rippling the carry inside the segment and forming sum = p ^ c.
module pg_seg_adder #(
  parameter int SEG_W = 32
) (
  input  logic [SEG_W-1:0] x_i,
  input  logic [SEG_W-1:0] y_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o
);

  logic [SEG_W-1:0] p_s;
  logic [SEG_W-1:0] g_s;
  logic [SEG_W:0]   c_s;

  assign p_s = x_i ^ y_i;
  assign g_s = x_i & y_i;

  always_comb begin
    c_s    = '0;
    c_s[0] = cin_i;
    for (int i = 0; i < SEG_W; i++) begin
      c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
    end
  end

  assign sum_o  = p_s ^ c_s[SEG_W-1:0];
  assign cout_o = c_s[SEG_W];

endmodule

// File: rtl/mod_addsub_pipe.sv
// Segment-pipelined (a +/- b) mod q: NSEG carry-segment stages feeding one
// select stage, with a global-stall valid/ready stream on both sides.
module mod_addsub_pipe
  import ntt_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int SEG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_q,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  if ((WIDTH % SEG_W) != 0) begin : g_bad_cfg
    $error("mod_addsub_pipe: WIDTH must be a multiple of SEG_W");
  end

  logic             adv_s;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_res_q;
  logic [WIDTH-1:0] res_d;
  stage_ctl_t       last_ctl_s;
  logic [WIDTH-1:0] last_raw_s;
  logic [WIDTH-1:0] last_alt_s;

  assign adv_s    = ~out_valid_q | out_ready;
  assign in_ready = adv_s;

  // Stage k resolves segment k of both chains; unconsumed operand segments ride along.
  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int REM_W  = WIDTH - k * SEG_W;
    localparam int DONE_W = (k + 1) * SEG_W;

    stage_ctl_t        ctl_src_s;
    stage_ctl_t        ctl_d;
    stage_ctl_t        ctl_q;
    logic [REM_W-1:0]  rem_a_s;
    logic [REM_W-1:0]  rem_b_s;
    logic [REM_W-1:0]  rem_q_s;
    logic [DONE_W-1:0] raw_d;
    logic [DONE_W-1:0] alt_d;
    logic [DONE_W-1:0] raw_q;
    logic [DONE_W-1:0] alt_q;
    logic [SEG_W-1:0]  raw_seg_s;
    logic [SEG_W-1:0]  alt_seg_s;
    logic [SEG_W-1:0]  b_eff_s;
    logic [SEG_W-1:0]  q_eff_s;
    logic              sub_s;
    logic              raw_co_s;
    logic              alt_co_s;

    if (k == 0) begin : g_src
      // Sub enters the raw chain as +~b+1; add enters the alt chain as +~q+1.
      assign ctl_src_s = '{valid: in_valid, sub: mode_e'(in_sub),
                           raw_c: in_sub, alt_c: ~in_sub};
      assign rem_a_s   = in_a;
      assign rem_b_s   = in_b;
      assign rem_q_s   = in_q;
      assign raw_d     = raw_seg_s;
      assign alt_d     = alt_seg_s;
    end else begin : g_src
      assign ctl_src_s = g_stg[k-1].ctl_q;
      assign rem_a_s   = g_stg[k-1].g_hi.a_q;
      assign rem_b_s   = g_stg[k-1].g_hi.b_q;
      assign rem_q_s   = g_stg[k-1].g_hi.q_q;
      assign raw_d     = {raw_seg_s, g_stg[k-1].raw_q};
      assign alt_d     = {alt_seg_s, g_stg[k-1].alt_q};
    end

    assign sub_s   = (ctl_src_s.sub == MODE_SUB);
    assign b_eff_s = rem_b_s[SEG_W-1:0] ^ {SEG_W{sub_s}};
    assign q_eff_s = rem_q_s[SEG_W-1:0] ^ {SEG_W{~sub_s}};

    pg_seg_adder #(.SEG_W(SEG_W)) u_raw (
      .x_i    (rem_a_s[SEG_W-1:0]),
      .y_i    (b_eff_s),
      .cin_i  (ctl_src_s.raw_c),
      .sum_o  (raw_seg_s),
      .cout_o (raw_co_s)
    );

    pg_seg_adder #(.SEG_W(SEG_W)) u_alt (
      .x_i    (raw_seg_s),
      .y_i    (q_eff_s),
      .cin_i  (ctl_src_s.alt_c),
      .sum_o  (alt_seg_s),
      .cout_o (alt_co_s)
    );

    assign ctl_d = '{valid: ctl_src_s.valid, sub: ctl_src_s.sub,
                     raw_c: raw_co_s, alt_c: alt_co_s};

    // Stage control, carries and completed low result segments.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ctl_q <= '0;
        raw_q <= '0;
        alt_q <= '0;
      end else if (adv_s) begin
        ctl_q <= ctl_d;
        raw_q <= raw_d;
        alt_q <= alt_d;
      end
    end

    if (k < NSEG - 1) begin : g_hi
      localparam int HI_W = REM_W - SEG_W;

      logic [HI_W-1:0] a_q;
      logic [HI_W-1:0] b_q;
      logic [HI_W-1:0] q_q;

      // Operand and modulus segments still waiting for their stage.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          q_q <= '0;
        end else if (adv_s) begin
          a_q <= rem_a_s[REM_W-1:SEG_W];
          b_q <= rem_b_s[REM_W-1:SEG_W];
          q_q <= rem_q_s[REM_W-1:SEG_W];
        end
      end
    end
  end

  assign last_ctl_s = g_stg[NSEG-1].ctl_q;
  assign last_raw_s = g_stg[NSEG-1].raw_q;
  assign last_alt_s = g_stg[NSEG-1].alt_q;

  // Add: take raw - q when raw overflowed or raw >= q. Sub: add q back on borrow.
  always_comb begin
    res_d = last_raw_s;
    if (last_ctl_s.sub == MODE_SUB) begin
      if (last_ctl_s.raw_c) begin
        res_d = last_raw_s;
      end else begin
        res_d = last_alt_s;
      end
    end else begin
      if (last_ctl_s.raw_c | last_ctl_s.alt_c) begin
        res_d = last_alt_s;
      end else begin
        res_d = last_raw_s;
      end
    end
  end

  // Output register; the result only reloads when a valid beat arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
    end else if (adv_s) begin
      out_valid_q <= last_ctl_s.valid;
      if (last_ctl_s.valid) begin
        out_res_q <= res_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed and random checks of mod_addsub_pipe (WIDTH=128, SEG_W=32) against
// hand-computed values and a 129-bit reference model.
module tb_mod_addsub_pipe;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_q;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mod_addsub_pipe #(.WIDTH(W), .SEG_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_q      (in_q),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
  );

  function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] q, input logic sub);
    logic [W:0] s;
    if (!sub) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
    end else if (a >= b) begin
      s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, q} - {1'b0, b};
    end
    return s[W-1:0];
  endfunction

  // Send one beat into an empty pipe and wait (bounded) for its result.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic sub, output int lat, output logic [W-1:0] res);
    @(negedge clk);
    in_a = a; in_b = b; in_q = q; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_q = '0; in_sub = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (out_res !== 128'd0) begin n_fail++; $display("FAIL reset_out_res: got %h expected 0", out_res); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_small_mod();
    logic [W-1:0] va[4];
    logic [W-1:0] vb[4];
    logic [W-1:0] ve[4];
    logic         vs[4];
    logic [W-1:0] res;
    int           lat;
    va = '{128'd10, 128'd8, 128'd3, 128'd5};
    vb = '{128'd9,  128'd9, 128'd5, 128'd5};
    vs = '{1'b0,    1'b0,   1'b1,   1'b1};
    ve = '{128'd2,  128'd0, 128'd15, 128'd0};
    for (int i = 0; i < 4; i++) begin
      run_one(va[i], vb[i], 128'd17, vs[i], lat, res);
      n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL small_lat[%0d]: got %0d expected 5", i, lat); end
      n_chk++; if (res !== ve[i]) begin n_fail++; $display("FAIL small_res[%0d]: got %0d expected %0d", i, res, ve[i]); end
    end
  endtask

  task automatic test_seg_carry();
    logic [W-1:0] q;
    logic [W-1:0] res;
    int           lat;
    q = 128'd1 << 100;
    run_one((128'd1 << 32) - 128'd1, 128'd1, q, 1'b0, lat, res);
    n_chk++; if (res !== (128'd1 << 32)) begin n_fail++; $display("FAIL seg_carry_add: got %h expected %h", res, 128'd1 << 32); end
    run_one(128'd1 << 64, 128'd1, q, 1'b1, lat, res);
    n_chk++; if (res !== ((128'd1 << 64) - 128'd1)) begin n_fail++; $display("FAIL seg_borrow_sub: got %h expected %h", res, (128'd1 << 64) - 128'd1); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] q;
    logic [W-1:0] res;
    int           lat;
    q = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61;
    run_one(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF60, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF60, q, 1'b0, lat, res);
    n_chk++; if (res !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF5F) begin n_fail++; $display("FAIL overflow_add: got %h expected ffff...ff5f", res); end
    run_one(128'd0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF60, q, 1'b1, lat, res);
    n_chk++; if (res !== 128'd1) begin n_fail++; $display("FAIL zero_minus_qm1: got %h expected 1", res); end
    run_one(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF60, 128'd1, q, 1'b0, lat, res);
    n_chk++; if (res !== 128'd0) begin n_fail++; $display("FAIL big_sum_eq_q: got %h expected 0", res); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta[32];
    logic [W-1:0] tb[32];
    logic [W-1:0] tq[32];
    logic         ts[32];
    logic [W-1:0] exp_r[32];
    int           ridx;
    int           first_c;
    bit           ready_ok;
    bit           consec_ok;
    for (int i = 0; i < 32; i++) begin
      tq[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      tq[i][W-1] = 1'b1;
      ta[i] = {$urandom(), $urandom(), $urandom(), $urandom()} % tq[i];
      tb[i] = {$urandom(), $urandom(), $urandom(), $urandom()} % tq[i];
      ts[i] = 1'($urandom_range(0, 1));
      exp_r[i] = ref_model(ta[i], tb[i], tq[i], ts[i]);
    end
    ridx = 0; first_c = -1; ready_ok = 1'b1; consec_ok = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (ridx < 32) begin
          n_chk++; if (out_res !== exp_r[ridx]) begin n_fail++; $display("FAIL b2b_res[%0d]: got %h expected %h", ridx, out_res, exp_r[ridx]); end
          if (first_c < 0) first_c = c;
          else if (c != first_c + ridx) consec_ok = 1'b0;
        end
        ridx++;
      end
      if (c < 32) begin
        if (in_ready !== 1'b1) ready_ok = 1'b0;
        in_valid = 1'b1; in_a = ta[c]; in_b = tb[c]; in_q = tq[c]; in_sub = ts[c];
      end else begin
        in_valid = 1'b0;
      end
    end
    n_chk++; if (ridx !== 32) begin n_fail++; $display("FAIL b2b_count: got %0d expected 32", ridx); end
    n_chk++; if (first_c !== 5) begin n_fail++; $display("FAIL b2b_first_cycle: got %0d expected 5", first_c); end
    n_chk++; if (consec_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_consecutive: got %b expected 1", consec_ok); end
    n_chk++; if (ready_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 1", ready_ok); end
  endtask

  task automatic test_stall();
    logic [W-1:0] ta[12];
    logic [W-1:0] tb[12];
    logic         ts[12];
    logic [W-1:0] exp_r[12];
    logic [W-1:0] held;
    int           sent;
    int           rcv;
    int           stall_cycles;
    bit           have_held;
    bit           hold_ok;
    bit           ready_low_ok;
    bit           extra;
    for (int i = 0; i < 12; i++) begin
      ta[i] = 128'(i * 50 + 1);
      tb[i] = 128'(999 - i * 30);
      ts[i] = 1'(i % 2);
      exp_r[i] = ref_model(ta[i], tb[i], 128'd1000, ts[i]);
    end
    sent = 0; rcv = 0; stall_cycles = 0;
    have_held = 1'b0; hold_ok = 1'b1; ready_low_ok = 1'b1; held = '0;
    in_q = 128'd1000;
    for (int c = 0; c < 60 && rcv < 12; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 12);
      if (sent < 12) begin
        in_valid = 1'b1; in_a = ta[sent]; in_b = tb[sent]; in_sub = ts[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        stall_cycles++;
        if (in_ready !== 1'b0) ready_low_ok = 1'b0;
        if (!have_held) begin held = out_res; have_held = 1'b1; end
        else if (out_res !== held) hold_ok = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_chk++; if (out_res !== exp_r[rcv]) begin n_fail++; $display("FAIL stall_res[%0d]: got %0d expected %0d", rcv, out_res, exp_r[rcv]); end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    n_chk++; if (rcv !== 12) begin n_fail++; $display("FAIL stall_count: got %0d expected 12", rcv); end
    n_chk++; if (sent !== 12) begin n_fail++; $display("FAIL stall_sent: got %0d expected 12", sent); end
    n_chk++; if (stall_cycles !== 6) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 6", stall_cycles); end
    n_chk++; if (ready_low_ok !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready_low: got %b expected 1", ready_low_ok); end
    n_chk++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL stall_res_hold: got %b expected 1", hold_ok); end
    n_chk++; if (extra !== 1'b0) begin n_fail++; $display("FAIL stall_duplicate: got %b expected 0", extra); end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] res;
    int           lat;
    bit           stale;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 128'(i + 1); in_b = 128'd2; in_q = 128'd17; in_sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (out_res !== 128'd0) begin n_fail++; $display("FAIL midrst_out_res: got %h expected 0", out_res); end
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_chk++; if (stale !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: got %b expected 0", stale); end
    run_one(128'd4, 128'd5, 128'd17, 1'b0, lat, res);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL midrst_lat: got %0d expected 5", lat); end
    n_chk++; if (res !== 128'd9) begin n_fail++; $display("FAIL midrst_res: got %0d expected 9", res); end
  endtask

  initial begin
    test_reset();
    test_small_mod();
    test_seg_carry();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
